// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Hazard logic and the bubble counter exist only when ID_EX_HAZARD_DETECT_EN is defined.
module id_ex_stage (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instruction,
  input  logic        id_valid,
  input  logic [31:0] read_data1,
  input  logic [31:0] read_data2,
  input  logic [31:0] extended_bits,
  input  logic        RegWrite,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemtoReg,
  input  logic        ALUSrc,
  input  logic        RegDst,
  input  logic        Branch,
  input  logic [1:0]  ALUOp,
  input  logic        flush,
  output logic        ex_valid,
  output logic [31:0] ex_read_data1,
  output logic [31:0] ex_read_data2,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_rd,
  output logic [4:0]  ex_shamt,
  output logic [5:0]  ex_funct,
  output logic        ex_RegWrite,
  output logic        ex_MemRead,
  output logic        ex_MemWrite,
  output logic        ex_MemtoReg,
  output logic        ex_ALUSrc,
  output logic        ex_RegDst,
  output logic        ex_Branch,
  output logic [1:0]  ex_ALUOp,
  output logic        stall,
  output logic [15:0] bubble_count
);

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned FIELD_W     = 26;
  localparam int unsigned CTRL_W      = 9;
  localparam int unsigned CNT_W       = 16;
  localparam int unsigned MEMREAD_BIT = 7;

  logic                ex_valid_q, ex_valid_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [FIELD_W-1:0]  field_q, field_d;
  logic [DATA_W-1:0]   rd1_q, rd1_d;
  logic [DATA_W-1:0]   rd2_q, rd2_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic [CTRL_W-1:0]   ctrl_in;
  logic                hazard_c;
  logic                opcode_unused;

  assign ctrl_in = {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, Branch, ALUOp};
  // Opcode is fully decoded upstream into the control inputs.
  assign opcode_unused = ^instruction[31:26];

  // Next EX state: flush and bubble both squash the slot and zero every field.
  always_comb begin
    ex_valid_d = id_valid;
    ctrl_d     = id_valid ? ctrl_in : CTRL_W'(0);
    field_d    = instruction[FIELD_W-1:0];
    rd1_d      = read_data1;
    rd2_d      = read_data2;
    imm_d      = extended_bits;
    if (flush || hazard_c) begin
      ex_valid_d = 1'b0;
      ctrl_d     = CTRL_W'(0);
      field_d    = FIELD_W'(0);
      rd1_d      = DATA_W'(0);
      rd2_d      = DATA_W'(0);
      imm_d      = DATA_W'(0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ex_valid_q <= 1'b0;
      ctrl_q     <= CTRL_W'(0);
      field_q    <= FIELD_W'(0);
      rd1_q      <= DATA_W'(0);
      rd2_q      <= DATA_W'(0);
      imm_q      <= DATA_W'(0);
    end else begin
      ex_valid_q <= ex_valid_d;
      ctrl_q     <= ctrl_d;
      field_q    <= field_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      imm_q      <= imm_d;
    end
  end

`ifdef ID_EX_HAZARD_DETECT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] bubble_count_q, bubble_count_d;

  // Load in EX whose destination (never $0) is a source of the decode instruction.
  assign hazard_c = ex_valid_q && ctrl_q[MEMREAD_BIT] && (field_q[20:16] != 5'd0) && id_valid &&
                    ((field_q[20:16] == instruction[25:21]) || (field_q[20:16] == instruction[20:16]));

  always_comb begin
    bubble_count_d = bubble_count_q;
    if (hazard_c && !flush && (bubble_count_q != CNT_MAX)) begin
      bubble_count_d = bubble_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) bubble_count_q <= CNT_W'(0);
    else          bubble_count_q <= bubble_count_d;
  end

  assign bubble_count = bubble_count_q;
`else
  assign hazard_c     = 1'b0;
  assign bubble_count = CNT_W'(0);
`endif

  assign stall = hazard_c && !flush;

  assign ex_valid      = ex_valid_q;
  assign ex_read_data1 = rd1_q;
  assign ex_read_data2 = rd2_q;
  assign ex_imm        = imm_q;
  assign ex_rs         = field_q[25:21];
  assign ex_rt         = field_q[20:16];
  assign ex_rd         = field_q[15:11];
  assign ex_shamt      = field_q[10:6];
  assign ex_funct      = field_q[5:0];
  assign {ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg,
          ex_ALUSrc, ex_RegDst, ex_Branch, ex_ALUOp} = ctrl_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of pass-through, load-use bubbles, flush priority, reset and saturation.
// Expectations follow ID_EX_HAZARD_DETECT_EN the same way the design build does.
module tb_id_ex_stage;

`ifdef ID_EX_HAZARD_DETECT_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif

  localparam logic [31:0] ADD_3_1_2 = 32'h0022_1820;
  localparam logic [31:0] ADD_3_2_1 = 32'h0041_1820;
  localparam logic [31:0] ADD_3_0_1 = 32'h0001_1820;
  localparam logic [31:0] SUB_4_6_5 = 32'h00C5_2022;
  localparam logic [31:0] LW_2_29   = 32'h8FA2_0000;
  localparam logic [31:0] LW_0_29   = 32'h8FA0_0000;
  localparam logic [31:0] LW_5_29   = 32'h8FA5_0000;
  localparam logic [8:0]  C_RTYPE   = 9'b1_0_0_0_0_1_0_10;
  localparam logic [8:0]  C_LW      = 9'b1_1_0_1_1_0_0_00;

  logic        clk, reset_n, id_valid, flush;
  logic [31:0] instruction, read_data1, read_data2, extended_bits;
  logic [8:0]  ctrl_in;
  logic        RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, Branch;
  logic [1:0]  ALUOp;
  logic        ex_valid, stall;
  logic [31:0] ex_read_data1, ex_read_data2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;
  logic [5:0]  ex_funct;
  logic        ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_ALUSrc, ex_RegDst, ex_Branch;
  logic [1:0]  ex_ALUOp;
  logic [15:0] bubble_count;
  logic [8:0]  ex_ctrl;
  int          n_cmp, n_bad;

  assign {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, Branch, ALUOp} = ctrl_in;
  assign ex_ctrl = {ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_ALUSrc, ex_RegDst, ex_Branch, ex_ALUOp};

  id_ex_stage dut (
    .clk(clk), .reset_n(reset_n), .instruction(instruction), .id_valid(id_valid),
    .read_data1(read_data1), .read_data2(read_data2), .extended_bits(extended_bits),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .ALUSrc(ALUSrc), .RegDst(RegDst), .Branch(Branch), .ALUOp(ALUOp), .flush(flush),
    .ex_valid(ex_valid), .ex_read_data1(ex_read_data1), .ex_read_data2(ex_read_data2),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt),
    .ex_funct(ex_funct), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
    .ex_MemWrite(ex_MemWrite), .ex_MemtoReg(ex_MemtoReg), .ex_ALUSrc(ex_ALUSrc),
    .ex_RegDst(ex_RegDst), .ex_Branch(ex_Branch), .ex_ALUOp(ex_ALUOp),
    .stall(stall), .bubble_count(bubble_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] imm, input logic [8:0] c,
                       input logic fl);
    id_valid = v; instruction = ins; read_data1 = d1; read_data2 = d2;
    extended_bits = imm; ctrl_in = c; flush = fl;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b1, ADD_3_1_2, 32'hDEAD_BEEF, 32'h1234_5678, 32'hFFFF_FFFF, 9'h1FF, 1'b0);
    step();
    step();
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %0h want 0", ex_valid); end
    n_cmp++; if (ex_RegWrite !== 1'b0) begin n_bad++; $display("FAIL rst_regwrite: got %0h want 0", ex_RegWrite); end
    n_cmp++; if (ex_read_data1 !== 32'h0) begin n_bad++; $display("FAIL rst_rd1: got %0h want 0", ex_read_data1); end
    n_cmp++; if (bubble_count !== 16'h0) begin n_bad++; $display("FAIL rst_bubbles: got %0h want 0", bubble_count); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %0h want 0", stall); end
    reset_n = 1'b1;
  endtask

  task automatic test_pass_through();
    drive(1'b1, ADD_3_1_2, 32'd5, 32'd7, 32'h0000_1820, C_RTYPE, 1'b0);
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL pt_stall: got %0h want 0", stall); end
    step();
    n_cmp++; if (ex_valid !== 1'b1) begin n_bad++; $display("FAIL pt_valid: got %0h want 1", ex_valid); end
    n_cmp++; if ({ex_rs, ex_rt, ex_rd, ex_shamt} !== {5'd1, 5'd2, 5'd3, 5'd0})
      begin n_bad++; $display("FAIL pt_regs: got %0d/%0d/%0d/%0d want 1/2/3/0", ex_rs, ex_rt, ex_rd, ex_shamt); end
    n_cmp++; if (ex_funct !== 6'h20) begin n_bad++; $display("FAIL pt_funct: got %0h want 20", ex_funct); end
    n_cmp++; if (ex_read_data1 !== 32'd5 || ex_read_data2 !== 32'd7)
      begin n_bad++; $display("FAIL pt_data: got %0d/%0d want 5/7", ex_read_data1, ex_read_data2); end
    n_cmp++; if (ex_imm !== 32'h0000_1820) begin n_bad++; $display("FAIL pt_imm: got %0h want 1820", ex_imm); end
    n_cmp++; if (ex_ctrl !== C_RTYPE) begin n_bad++; $display("FAIL pt_ctrl: got %0h want %0h", ex_ctrl, C_RTYPE); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL pt_stall_after: got %0h want 0", stall); end
  endtask

  task automatic test_reset_async();
    reset_n = 1'b0;
    #2;
    n_cmp++; if (ex_valid !== 1'b1 || ex_read_data1 !== 32'd5)
      begin n_bad++; $display("FAIL arst_hold: got %0h/%0d want 1/5", ex_valid, ex_read_data1); end
    step();
    n_cmp++; if (ex_valid !== 1'b0 || ex_read_data1 !== 32'd0)
      begin n_bad++; $display("FAIL arst_clear: got %0h/%0d want 0/0", ex_valid, ex_read_data1); end
    reset_n = 1'b1;
  endtask

  task automatic test_invalid_slot();
    drive(1'b0, ADD_3_1_2, 32'hAAAA_0000, 32'h5555, 32'hFFFF_FFFF, 9'h1FF, 1'b0);
    step();
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL inv_valid: got %0h want 0", ex_valid); end
    n_cmp++; if (ex_ctrl !== 9'h0) begin n_bad++; $display("FAIL inv_ctrl: got %0h want 0", ex_ctrl); end
    n_cmp++; if (ex_read_data1 !== 32'hAAAA_0000 || ex_imm !== 32'hFFFF_FFFF || ex_rs !== 5'd1)
      begin n_bad++; $display("FAIL inv_data: got %0h/%0h/%0d want aaaa0000/ffffffff/1", ex_read_data1, ex_imm, ex_rs); end
  endtask

  task automatic test_load_use();
    drive(1'b1, LW_2_29, 32'h100, 32'h0, 32'h0, C_LW, 1'b0);
    step();
    n_cmp++; if (ex_valid !== 1'b1 || ex_rt !== 5'd2 || ex_rs !== 5'd29)
      begin n_bad++; $display("FAIL lu_lw: got v=%0h rt=%0d rs=%0d want 1/2/29", ex_valid, ex_rt, ex_rs); end
    n_cmp++; if (ex_ctrl !== C_LW) begin n_bad++; $display("FAIL lu_lw_ctrl: got %0h want %0h", ex_ctrl, C_LW); end
    drive(1'b1, ADD_3_2_1, 32'd9, 32'd4, 32'h1820, C_RTYPE, 1'b0);
    #1;
    n_cmp++; if (stall !== HZ) begin n_bad++; $display("FAIL lu_stall: got %0h want %0h", stall, HZ); end
    step();
    n_cmp++; if (ex_valid !== !HZ || ex_RegWrite !== !HZ)
      begin n_bad++; $display("FAIL lu_bubble: got %0h/%0h want %0h", ex_valid, ex_RegWrite, !HZ); end
    n_cmp++; if (bubble_count !== (HZ ? 16'd1 : 16'd0))
      begin n_bad++; $display("FAIL lu_count: got %0d want %0d", bubble_count, HZ ? 1 : 0); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL lu_stall_drop: got %0h want 0", stall); end
    step();
    n_cmp++; if (ex_valid !== 1'b1 || ex_rs !== 5'd2 || ex_rt !== 5'd1 || ex_rd !== 5'd3 || ex_read_data1 !== 32'd9)
      begin n_bad++; $display("FAIL lu_add: got v=%0h rs=%0d rt=%0d rd=%0d d1=%0d want 1/2/1/3/9", ex_valid, ex_rs, ex_rt, ex_rd, ex_read_data1); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL lu_stall_end: got %0h want 0", stall); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, LW_5_29, 32'h200, 32'h0, 32'h0, C_LW, 1'b0);
    step();
    drive(1'b1, SUB_4_6_5, 32'd6, 32'd5, 32'h2022, C_RTYPE, 1'b0);
    #1;
    n_cmp++; if (stall !== HZ) begin n_bad++; $display("FAIL b2b_stall_rt: got %0h want %0h", stall, HZ); end
    step();
    n_cmp++; if (ex_valid !== !HZ) begin n_bad++; $display("FAIL b2b_bubble: got %0h want %0h", ex_valid, !HZ); end
    n_cmp++; if (bubble_count !== (HZ ? 16'd2 : 16'd0))
      begin n_bad++; $display("FAIL b2b_count: got %0d want %0d", bubble_count, HZ ? 2 : 0); end
    step();
    n_cmp++; if (ex_valid !== 1'b1 || ex_rd !== 5'd4 || ex_funct !== 6'h22)
      begin n_bad++; $display("FAIL b2b_sub: got v=%0h rd=%0d f=%0h want 1/4/22", ex_valid, ex_rd, ex_funct); end
  endtask

  task automatic test_no_hazard();
    drive(1'b1, LW_0_29, 32'h300, 32'h0, 32'h0, C_LW, 1'b0);
    step();
    drive(1'b1, ADD_3_0_1, 32'd1, 32'd2, 32'h1820, C_RTYPE, 1'b0);
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL zero_stall: got %0h want 0", stall); end
    step();
    n_cmp++; if (ex_valid !== 1'b1 || ex_rs !== 5'd0 || bubble_count !== (HZ ? 16'd2 : 16'd0))
      begin n_bad++; $display("FAIL zero_load: got v=%0h rs=%0d bc=%0d", ex_valid, ex_rs, bubble_count); end
    drive(1'b1, LW_2_29, 32'h100, 32'h0, 32'h0, C_LW, 1'b0);
    step();
    drive(1'b0, ADD_3_2_1, 32'd9, 32'd4, 32'h1820, C_RTYPE, 1'b0);
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL idle_stall: got %0h want 0", stall); end
    step();
    n_cmp++; if (ex_valid !== 1'b0 || bubble_count !== (HZ ? 16'd2 : 16'd0))
      begin n_bad++; $display("FAIL idle_slot: got v=%0h bc=%0d", ex_valid, bubble_count); end
  endtask

  task automatic test_flush_hazard();
    drive(1'b1, LW_2_29, 32'h100, 32'h0, 32'h0, C_LW, 1'b0);
    step();
    drive(1'b1, ADD_3_2_1, 32'd9, 32'd4, 32'h1820, C_RTYPE, 1'b1);
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL fl_stall: got %0h want 0", stall); end
    step();
    n_cmp++; if (ex_valid !== 1'b0 || ex_ctrl !== 9'h0)
      begin n_bad++; $display("FAIL fl_squash: got v=%0h ctrl=%0h want 0/0", ex_valid, ex_ctrl); end
    n_cmp++; if (ex_read_data1 !== 32'h0 || ex_imm !== 32'h0 || ex_rs !== 5'd0)
      begin n_bad++; $display("FAIL fl_zero: got %0h/%0h/%0d want 0", ex_read_data1, ex_imm, ex_rs); end
    n_cmp++; if (bubble_count !== (HZ ? 16'd2 : 16'd0))
      begin n_bad++; $display("FAIL fl_count: got %0d want %0d", bubble_count, HZ ? 2 : 0); end
    flush = 1'b0;
  endtask

  task automatic test_reset_mid_bubble();
    drive(1'b1, LW_2_29, 32'h100, 32'h0, 32'h0, C_LW, 1'b0);
    step();
    drive(1'b1, ADD_3_2_1, 32'd9, 32'd4, 32'h1820, C_RTYPE, 1'b0);
    reset_n = 1'b0;
    step();
    n_cmp++; if (ex_valid !== 1'b0 || bubble_count !== 16'd0 || ex_read_data1 !== 32'd0)
      begin n_bad++; $display("FAIL rmb_clear: got v=%0h bc=%0d d1=%0h want 0/0/0", ex_valid, bubble_count, ex_read_data1); end
    reset_n = 1'b1;
    step();
    n_cmp++; if (ex_valid !== 1'b1 || ex_rs !== 5'd2 || bubble_count !== 16'd0)
      begin n_bad++; $display("FAIL rmb_resume: got v=%0h rs=%0d bc=%0d want 1/2/0", ex_valid, ex_rs, bubble_count); end
  endtask

  task automatic test_saturation();
`ifdef ID_EX_HAZARD_DETECT_EN
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 9'h0, 1'b0);
    force dut.bubble_count_d = 16'hFFFE;
    step();
    release dut.bubble_count_d;
    n_cmp++; if (bubble_count !== 16'hFFFE) begin n_bad++; $display("FAIL sat_preload: got %0h want fffe", bubble_count); end
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, LW_2_29, 32'h100, 32'h0, 32'h0, C_LW, 1'b0);
      step();
      drive(1'b1, ADD_3_2_1, 32'd9, 32'd4, 32'h1820, C_RTYPE, 1'b0);
      #1;
      n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL sat_stall%0d: got %0h want 1", k, stall); end
      step();
      n_cmp++; if (bubble_count !== 16'hFFFF) begin n_bad++; $display("FAIL sat_count%0d: got %0h want ffff", k, bubble_count); end
      step();
    end
`else
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, LW_2_29, 32'h100, 32'h0, 32'h0, C_LW, 1'b0);
      step();
      drive(1'b1, ADD_3_2_1, 32'd9, 32'd4, 32'h1820, C_RTYPE, 1'b0);
      #1;
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL off_stall%0d: got %0h want 0", k, stall); end
      step();
      n_cmp++; if (bubble_count !== 16'h0 || ex_valid !== 1'b1)
        begin n_bad++; $display("FAIL off_load%0d: got bc=%0h v=%0h want 0/1", k, bubble_count, ex_valid); end
    end
`endif
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_pass_through();
    test_reset_async();
    test_invalid_slot();
    test_load_use();
    test_back_to_back();
    test_no_hazard();
    test_flush_hazard();
    test_reset_mid_bubble();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
